// File: rtl/candle_pkg.sv
// Shared constants, level type and LFSR rotate helper for the candle LED driver.
package candle_pkg;

  localparam int unsigned NUM_CANDLES = 8;
  localparam int unsigned LFSR_WIDTH  = 16;
  localparam int unsigned LFSR_IDX_W  = 4;
  localparam logic [LFSR_WIDTH-1:0] LFSR_MASK = 16'hB400;
  localparam int unsigned LEVEL_BITS  = 8;

  typedef logic [LEVEL_BITS-1:0] level_t;

  // Rotate right by n positions.
  function automatic logic [LFSR_WIDTH-1:0] rotr(input logic [LFSR_WIDTH-1:0] v,
                                                 input int unsigned n);
    logic [LFSR_WIDTH-1:0] r;
    for (int unsigned k = 0; k < LFSR_WIDTH; k++) begin
      r[k] = v[LFSR_IDX_W'((k + n) % LFSR_WIDTH)];
    end
    return r;
  endfunction

endpackage

// File: rtl/candle_pwm_channel.sv
// One candle: saturating brightness ramp, flicker duty select and registered PWM compare.
module candle_pwm_channel
  import candle_pkg::*;
#(
  parameter int unsigned PWM_BITS     = LEVEL_BITS,
  parameter int unsigned RAMP_STEP    = 8,
  parameter int unsigned FLICKER_BITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic [PWM_BITS-1:0]     pwm_cnt,
  input  logic                    lit,
  input  logic [FLICKER_BITS-1:0] flick,
  input  logic                    flicker_en,
  output logic [PWM_BITS-1:0]     level,
  output logic                    led
);

  localparam logic [PWM_BITS-1:0] MAX    = '1;
  localparam logic [PWM_BITS:0]   STEP_W = (PWM_BITS + 1)'(RAMP_STEP);

  logic [PWM_BITS:0]   sum;
  logic [PWM_BITS:0]   diff;
  logic [PWM_BITS-1:0] next_level;
  logic [PWM_BITS-1:0] duty;

  // One extra bit on both sides so overflow and underflow show up as the MSB.
  always_comb begin
    sum  = {1'b0, level} + STEP_W;
    diff = {1'b0, level} - STEP_W;
    if (lit) begin
      next_level = (sum > {1'b0, MAX}) ? MAX : sum[PWM_BITS-1:0];
    end else begin
      next_level = diff[PWM_BITS] ? '0 : diff[PWM_BITS-1:0];
    end
  end

  always_comb begin
    duty = level;
    if (flicker_en && (level == MAX)) begin
      duty = MAX - PWM_BITS'(flick);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
      led   <= 1'b0;
    end else begin
      if (tick) begin
        level <= next_level;
      end
      led <= (duty == MAX) || (pwm_cnt < duty);
    end
  end

endmodule

// File: rtl/candle_flicker_driver.sv
// Drives eight candle LEDs with ramped PWM brightness and optional LFSR flicker.
module candle_flicker_driver
  import candle_pkg::*;
#(
  parameter int unsigned           TICK_DIV     = 50000,
  parameter int unsigned           PWM_BITS     = LEVEL_BITS,
  parameter int unsigned           RAMP_STEP    = 8,
  parameter int unsigned           FLICKER_BITS = 3,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                   sys_clk,
  input  logic                   clr_n,
  input  logic [NUM_CANDLES-1:0] candle_state,
  input  logic                   flicker_en,
  output logic [NUM_CANDLES-1:0] led,
  output logic                   all_lit,
  output logic                   ramping
);

  localparam int unsigned           CNT_W = $clog2(TICK_DIV);
  localparam logic [PWM_BITS-1:0]   MAX   = '1;
  // An all-zero seed would lock the LFSR up, so it is replaced by 1.
  localparam logic [LFSR_WIDTH-1:0] SEED  = (LFSR_SEED == '0) ? LFSR_WIDTH'(1) : LFSR_SEED;

  logic [CNT_W-1:0]      prescaler;
  logic                  tick;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [LFSR_WIDTH-1:0] lfsr;
  logic [PWM_BITS-1:0]   level [NUM_CANDLES];
  logic                  all_lit_c;
  logic                  ramping_c;

  assign tick = (prescaler == CNT_W'(TICK_DIV - 1));

  // Update-tick prescaler, free-running PWM counter and Galois LFSR.
  always_ff @(posedge sys_clk or negedge clr_n) begin
    if (!clr_n) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
      lfsr      <= SEED;
    end else begin
      prescaler <= tick ? '0 : prescaler + CNT_W'(1);
      pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
      if (tick) begin
        lfsr <= {1'b0, lfsr[LFSR_WIDTH-1:1]} ^ (lfsr[0] ? LFSR_MASK : '0);
      end
    end
  end

  for (genvar i = 0; i < NUM_CANDLES; i++) begin : g_chan
    localparam int unsigned ROT = 2 * i;
    logic [FLICKER_BITS-1:0] flick;

    assign flick = FLICKER_BITS'(rotr(lfsr, ROT));

    candle_pwm_channel #(
      .PWM_BITS    (PWM_BITS),
      .RAMP_STEP   (RAMP_STEP),
      .FLICKER_BITS(FLICKER_BITS)
    ) u_ch (
      .clk       (sys_clk),
      .rst_n     (clr_n),
      .tick      (tick),
      .pwm_cnt   (pwm_cnt),
      .lit       (candle_state[i]),
      .flick     (flick),
      .flicker_en(flicker_en),
      .level     (level[i]),
      .led       (led[i])
    );
  end

  always_comb begin
    all_lit_c = 1'b1;
    ramping_c = 1'b0;
    for (int i = 0; i < NUM_CANDLES; i++) begin
      all_lit_c = all_lit_c & (level[i] == MAX);
      ramping_c = ramping_c | (level[i] != (candle_state[i] ? MAX : '0));
    end
  end

  always_ff @(posedge sys_clk or negedge clr_n) begin
    if (!clr_n) begin
      all_lit <= 1'b0;
      ramping <= 1'b0;
    end else begin
      all_lit <= all_lit_c;
      ramping <= ramping_c;
    end
  end

endmodule

// File: tb/tb_candle_flicker_driver.sv
// Directed bench for candle_flicker_driver with a cycle-level reference model and scoreboard.
module tb_candle_flicker_driver;
  import candle_pkg::*;

  localparam int TD = 4;
  localparam int RS = 8;

  logic       sys_clk = 1'b0;
  logic       clr_n;
  logic [7:0] candle_state;
  logic       flicker_en;
  logic [7:0] led;
  logic       all_lit;
  logic       ramping;

  logic       clr2_n;
  logic [7:0] cs2;
  logic       fe2;
  logic [7:0] led2;
  logic       all_lit2;
  logic       ramping2;

  always #5 sys_clk = ~sys_clk;

  candle_flicker_driver #(.TICK_DIV(TD)) dut (
    .sys_clk(sys_clk), .clr_n(clr_n), .candle_state(candle_state),
    .flicker_en(flicker_en), .led(led), .all_lit(all_lit), .ramping(ramping)
  );

  candle_flicker_driver #(.TICK_DIV(1024), .RAMP_STEP(128)) dut_d (
    .sys_clk(sys_clk), .clr_n(clr2_n), .candle_state(cs2),
    .flicker_en(fe2), .led(led2), .all_lit(all_lit2), .ramping(ramping2)
  );

  typedef struct packed {
    logic [7:0] led;
    logic       all_lit;
    logic       ramping;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;

  int          m_cnt;
  level_t      m_pwm;
  level_t      m_pwm_pre;
  logic [15:0] m_lfsr;
  level_t      m_lvl [8];
  bit          m_tick;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] m_lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [2:0] m_flick(input logic [15:0] v, input int i);
    return 3'((v >> (2 * i)) | (v << (16 - 2 * i)));
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_pwm  = '0;
    m_lfsr = 16'hACE1;
    for (int i = 0; i < 8; i++) m_lvl[i] = '0;
  endtask

  // Predict the post-edge outputs, advance one clock, then compare.
  task automatic step();
    exp_t e;
    int   duty;
    e = '0;
    if (clr_n) begin
      e.all_lit = 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (flicker_en && m_lvl[i] == 8'hFF) duty = 255 - int'(m_flick(m_lfsr, i));
        else duty = int'(m_lvl[i]);
        e.led[i] = (duty == 255) || (int'(m_pwm) < duty);
        if (m_lvl[i] != 8'hFF) e.all_lit = 1'b0;
        if (m_lvl[i] != (candle_state[i] ? 8'hFF : 8'h00)) e.ramping = 1'b1;
      end
    end
    sb_q.push_back(e);
    m_pwm_pre = m_pwm;
    @(posedge sys_clk);
    #1;
    m_tick = 1'b0;
    if (!clr_n) begin
      model_reset();
    end else begin
      if (m_cnt == TD - 1) begin
        m_tick = 1'b1;
        m_cnt  = 0;
        for (int i = 0; i < 8; i++) begin
          if (candle_state[i]) m_lvl[i] = (int'(m_lvl[i]) + RS > 255) ? 8'hFF : 8'(int'(m_lvl[i]) + RS);
          else m_lvl[i] = (int'(m_lvl[i]) < RS) ? 8'h00 : 8'(int'(m_lvl[i]) - RS);
        end
        m_lfsr = m_lfsr_next(m_lfsr);
      end else begin
        m_cnt++;
      end
      m_pwm = m_pwm + 8'd1;
    end
    e = sb_q.pop_front();
    chk("sb_led", 32'(led), 32'(e.led));
    chk("sb_all_lit", 32'(all_lit), 32'(e.all_lit));
    chk("sb_ramping", 32'(ramping), 32'(e.ramping));
  endtask

  task automatic step_to_tick();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!m_tick && n < 2 * TD);
    chk("tick_wait", 32'(m_tick), 32'd1);
  endtask

  task automatic wait_all_lit(input int bound);
    int n;
    n = 0;
    while (all_lit !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    chk("all_lit_wait", 32'(all_lit), 32'd1);
  endtask

  initial begin
    int hi_cnt;
    int n;
    clr_n = 1'b0; candle_state = 8'hFF; flicker_en = 1'b0;
    clr2_n = 1'b0; cs2 = 8'h01; fe2 = 1'b0;
    model_reset();
    m_tick = 1'b0;
    #2;
    chk("rst_led", 32'(led), 32'h00);
    chk("rst_all_lit", 32'(all_lit), 32'd0);
    chk("rst_ramping", 32'(ramping), 32'd0);
    repeat (3) step();

    // Ramp up candle 0 only.
    candle_state = 8'h01;
    clr_n = 1'b1;
    step();
    chk("ramp_start", 32'(ramping), 32'd1);
    repeat (129) step();
    for (int k = 0; k < 8; k++) begin
      step();
      chk("ramp_done_led", 32'(led), 32'h01);
      chk("ramp_done_ramping", 32'(ramping), 32'd0);
    end

    // Asynchronous reset in the middle of a ramp.
    candle_state = 8'hFF;
    repeat (40) step();
    chk("pre_rst_ramping", 32'(ramping), 32'd1);
    clr_n = 1'b0;
    #1;
    chk("async_led", 32'(led), 32'h00);
    chk("async_ramping", 32'(ramping), 32'd0);
    chk("async_level5", 32'(dut.g_chan[5].u_ch.level), 32'd0);
    model_reset();
    repeat (2) step();

    // Fade all candles from fully lit.
    clr_n = 1'b1;
    wait_all_lit(300);
    candle_state = 8'h00;
    step_to_tick();
    chk("fade_all_lit_hold", 32'(all_lit), 32'd1);
    step();
    chk("fade_all_lit_fall", 32'(all_lit), 32'd0);
    repeat (132) step();
    chk("fade_led", 32'(led), 32'h00);
    chk("fade_ramping", 32'(ramping), 32'd0);

    // Direction reversal on candle 3.
    candle_state = 8'h08;
    n = 0;
    while (m_lvl[3] != 8'd64 && n < 12) begin
      step_to_tick();
      n++;
    end
    chk("rev_64a", 32'(dut.g_chan[3].u_ch.level), 32'd64);
    candle_state = 8'h00;
    step_to_tick();
    chk("rev_56", 32'(dut.g_chan[3].u_ch.level), 32'd56);
    candle_state = 8'h08;
    step_to_tick();
    chk("rev_64b", 32'(dut.g_chan[3].u_ch.level), 32'd64);

    // Flicker on fully lit candles.
    candle_state = 8'hFF;
    flicker_en = 1'b1;
    wait_all_lit(400);
    for (int k = 0; k < 200; k++) begin
      step();
      if (m_pwm_pre < 8'd248) chk("flick_floor", 32'(led), 32'hFF);
    end
    flicker_en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("noflick_led", 32'(led), 32'hFF);
    end

    // Duty accuracy on the slow-tick instance.
    clr2_n = 1'b1;
    repeat (1023) step();
    chk("duty_pre_tick", 32'(dut_d.g_chan[0].u_ch.level), 32'd0);
    step();
    chk("duty_level", 32'(dut_d.g_chan[0].u_ch.level), 32'd128);
    hi_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      if (led2[0] === 1'b1) hi_cnt++;
      if (k % 32 == 0) chk("duty_other_leds", 32'(led2[7:1]), 32'd0);
    end
    chk("duty_high_count", 32'(hi_cnt), 32'd128);
    chk("duty_ramping", 32'(ramping2), 32'd1);
    chk("duty_all_lit", 32'(all_lit2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
